// File: rtl/run_control.sv
// Run controller: holds a processor in reset, releases it for a program run and
// stops it on a halt-word match or, when RUN_CONTROL_TIMEOUT_EN is defined, a watchdog timeout.
module run_control #(
    parameter int                     INSTR_WIDTH    = 32,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD      = '0,
    parameter int                     HALT_MATCH     = 1,
    parameter int                     RESET_CYCLES   = 1,
    parameter int                     TIMEOUT_CYCLES = 1024,
    parameter int                     CNT_WIDTH      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   cpu_reset,
    output logic                   running,
    output logic                   halted,
    output logic                   timed_out,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    // Counters only ever need to reach their limit minus one before the FSM moves on.
    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int MW = (HALT_MATCH > 1) ? $clog2(HALT_MATCH) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(HALT_MATCH - 1);

    if (HALT_MATCH < 1) begin : gBadHaltMatch
        $error("run_control: HALT_MATCH must be >= 1");
    end
    if (RESET_CYCLES < 1) begin : gBadResetCycles
        $error("run_control: RESET_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("run_control: TIMEOUT_CYCLES must be >= 1");
    end

    state_t               state_q, state_d;
    logic [HW-1:0]        holdCnt_q, holdCnt_d;
    logic [MW-1:0]        matchCnt_q, matchCnt_d;
    logic [CNT_WIDTH-1:0] runCnt_q, runCnt_d;
    logic                 done_q, done_d;
    logic                 isHaltWord;
    logic                 restart;
    logic                 timeoutHit;

    assign isHaltWord = (instruction == HALT_WORD);
    assign restart    = start && (state_q == S_IDLE || state_q == S_HALTED || state_q == S_TIMEOUT);

`ifdef RUN_CONTROL_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wdCnt_q, wdCnt_d;

    // Separate watchdog counter so the timeout still fires if cycle_count saturates first.
    always_comb begin
        wdCnt_d = wdCnt_q;
        if (restart) begin
            wdCnt_d = '0;
        end else if (state_q == S_RUN) begin
            wdCnt_d = wdCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdCnt_q <= '0;
        end else begin
            wdCnt_q <= wdCnt_d;
        end
    end

    assign timeoutHit = (state_q == S_RUN) && (wdCnt_q == WD_LAST);
    assign timed_out  = (state_q == S_TIMEOUT);
`else
    assign timeoutHit = 1'b0;
    assign timed_out  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        holdCnt_d  = holdCnt_q;
        matchCnt_d = matchCnt_q;
        runCnt_d   = runCnt_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (start) begin
                    state_d    = S_HOLD;
                    holdCnt_d  = '0;
                    matchCnt_d = '0;
                    runCnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (holdCnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (runCnt_q != '1) begin
                    runCnt_d = runCnt_q + 1'b1;
                end
                if (!isHaltWord) begin
                    matchCnt_d = '0;
                end else if (matchCnt_q != MATCH_LAST) begin
                    matchCnt_d = matchCnt_q + 1'b1;
                end
                // A halt match takes priority over a simultaneous watchdog expiry.
                if (isHaltWord && matchCnt_q == MATCH_LAST) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                end else if (timeoutHit) begin
                    state_d = S_TIMEOUT;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            holdCnt_q  <= '0;
            matchCnt_q <= '0;
            runCnt_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            holdCnt_q  <= holdCnt_d;
            matchCnt_q <= matchCnt_d;
            runCnt_q   <= runCnt_d;
            done_q     <= done_d;
        end
    end

    assign cpu_reset   = (state_q != S_RUN);
    assign running     = (state_q == S_RUN);
    assign halted      = (state_q == S_HALTED);
    assign done        = done_q;
    assign cycle_count = runCnt_q;

endmodule
